// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer for the execute stage: one-cycle multiply or
// 32-step restoring divide. Optional macro MULDIV_DIV_FASTPATH_EN enables early-out divides.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  func3,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  func3_q, func3_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] result_q, result_d;

    // Applies RV32M sign and corner-case rules to raw magnitude quotient/remainder.
    function automatic logic [31:0] div_fixup(input logic [1:0]  f3,
                                              input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [31:0] q,
                                              input logic [31:0] r);
        logic        sgn, na, nb;
        logic [31:0] qf, rf;
        sgn = ~f3[0];
        na  = sgn & a[31];
        nb  = sgn & b[31];
        if (b == 32'd0) begin
            qf = 32'hFFFF_FFFF;
            rf = a;
        end else begin
            qf = (na ^ nb) ? -q : q;
            rf = na ? -r : r;
        end
        return f3[1] ? rf : qf;
    endfunction

    logic        mul_a_sgn, mul_b_sgn;
    logic [63:0] mul_a, mul_b, prod;

    assign mul_a_sgn = (func3_q != 2'b11) & a_q[31];
    assign mul_b_sgn = ~func3_q[1] & b_q[31];
    assign mul_a     = {{32{mul_a_sgn}}, a_q};
    assign mul_b     = {{32{mul_b_sgn}}, b_q};
    assign prod      = mul_a * mul_b;

    logic        div_neg_b;
    logic [31:0] div_mag;
    logic [32:0] rem_shift, rem_trial;
    logic [31:0] rem_next, quo_next;

    assign div_neg_b = ~func3_q[0] & b_q[31];
    assign div_mag   = div_neg_b ? -b_q : b_q;
    assign rem_shift = {rem_q, quo_q[31]};
    assign rem_trial = rem_shift - {1'b0, div_mag};
    assign rem_next  = rem_trial[32] ? rem_shift[31:0] : rem_trial[31:0];
    assign quo_next  = {quo_q[30:0], ~rem_trial[32]};

`ifdef MULDIV_DIV_FASTPATH_EN
    logic        fast_hit;
    logic [31:0] fast_res;

    assign fast_hit = (op2 == 32'd0) ||
                      (~func3[0] && op1 == 32'h8000_0000 && op2 == 32'hFFFF_FFFF);
    assign fast_res = div_fixup(func3[1:0], op1, op2, 32'h8000_0000, 32'd0);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        func3_d  = func3_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    func3_d = func3[1:0];
                    a_d     = op1;
                    b_d     = op2;
                    cnt_d   = 5'd0;
                    rem_d   = 32'd0;
                    quo_d   = (~func3[0] & op1[31]) ? -op1 : op1;
                    if (!func3[2]) begin
                        state_d = StMul;
`ifdef MULDIV_DIV_FASTPATH_EN
                    end else if (fast_hit) begin
                        state_d  = StDone;
                        result_d = fast_res;
`endif
                    end else begin
                        state_d = StDiv;
                    end
                end
            end
            StMul: begin
                result_d = (func3_q == 2'b00) ? prod[31:0] : prod[63:32];
                state_d  = StDone;
            end
            StDiv: begin
                rem_d = rem_next;
                quo_d = quo_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d  = StDone;
                    result_d = div_fixup(func3_q, a_q, b_q, quo_next, rem_next);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A squash discards the op, including any result about to be written.
        if (flush) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            func3_q  <= 2'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            func3_q  <= func3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == StMul) || (state_q == StDiv);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign stall  = start & ~done & ~rst;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer; latencies follow MULDIV_DIV_FASTPATH_EN.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int vectors     = 0;
    int miscompares = 0;

`ifdef MULDIV_DIV_FASTPATH_EN
    localparam int FastLat  = 1;
    localparam int FastBusy = 0;
`else
    localparam int FastLat  = 33;
    localparam int FastBusy = 32;
`endif

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .func3  (func3),
        .op1    (op1),
        .op2    (op2),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Launch an op in the next cycle (T) and follow it to its done pulse.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int exp_busy);
        int   lat;
        int   busy_cnt;
        logic stall_ok;
        @(posedge clk);
        #1;
        start = 1'b1;
        func3 = f3;
        op1   = a;
        op2   = b;
        lat      = 0;
        busy_cnt = 0;
        stall_ok = 1'b1;
        @(negedge clk);
        while (!done && lat < 40) begin
            if (!stall) stall_ok = 1'b0;
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_res"}, result, exp_res);
        check_eq({tag, "_busy"}, busy_cnt, exp_busy);
        check_eq({tag, "_stall"}, {31'd0, stall_ok}, 32'd1);
        check_eq({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        logic seen_done;
        rst   = 1'b1;
        start = 1'b1;
        flush = 1'b0;
        func3 = 3'b000;
        op1   = 32'd0;
        op2   = 32'd0;

        @(negedge clk);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_result", result, 32'd0);

        run_op("mul", 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 1);
        run_op("mulh", 3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 2, 1);
        idle_cycle();
        run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 1);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1);
        idle_cycle();
        run_op("div", 3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, 32);
        run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, 32);
        idle_cycle();
        run_op("divu_z", 3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, FastLat, FastBusy);
        run_op("remu_z", 3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, FastLat, FastBusy);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FastLat, FastBusy);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, FastLat, FastBusy);
        run_op("div_negz", 3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, FastLat, FastBusy);
        idle_cycle();

        // Flush a divide ten cycles after launch.
        @(posedge clk);
        #1;
        start = 1'b1;
        func3 = 3'b100;
        op1   = 32'd100;
        op2   = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check_eq("flush_busy_pre", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_eq("flush_busy", {31'd0, busy}, 32'd0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check_eq("flush_no_done", {31'd0, seen_done}, 32'd0);
        check_eq("flush_result", result, 32'hFFFF_FFFF);

        // start and flush together in IDLE must not launch.
        @(posedge clk);
        #1;
        start = 1'b1;
        flush = 1'b1;
        func3 = 3'b000;
        op1   = 32'd3;
        op2   = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check_eq("sf_busy", {31'd0, busy}, 32'd0);
        seen_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check_eq("sf_no_done", {31'd0, seen_done}, 32'd0);
        check_eq("sf_result", result, 32'hFFFF_FFFF);

        run_op("b2b_mul", 3'b000, 32'd6, 32'd7, 32'h0000_002A, 2, 1);
        run_op("b2b_divu", 3'b101, 32'd100, 32'd7, 32'h0000_000E, 33, 32);
        idle_cycle();

        // Reset in the middle of a divide.
        @(posedge clk);
        #1;
        start = 1'b1;
        func3 = 3'b101;
        op1   = 32'd100;
        op2   = 32'd7;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("mrst_stall_in", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_eq("mrst_done", {31'd0, done}, 32'd0);
        check_eq("mrst_result", result, 32'd0);
        check_eq("mrst_stall", {31'd0, stall}, 32'd0);
        check_eq("mrst_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
